// File: rtl/gen_mask_sweep.sv
// Registered window mask generator: out[i] = (lo <= i < hi), with hi clamped to LIMIT.
// Sweep mode advances lo by one bit per clock until the window is empty.
module gen_mask_sweep #(
  parameter int WIDTH    = 32,
  parameter int LIMIT    = 31,
  parameter int RESET_LO = 8,
  parameter int RESET_HI = LIMIT,
  localparam int TW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [TW-1:0]    load_lo,
  input  logic [TW-1:0]    load_hi,
  input  logic             load_sweep,
  output logic [WIDTH-1:0] out,
  output logic [TW-1:0]    ones,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam int RST_HI_INT = (RESET_HI < LIMIT) ? RESET_HI : LIMIT;
  localparam logic [TW-1:0] LIMIT_TW  = TW'(LIMIT);
  localparam logic [TW-1:0] RST_LO_TW = TW'(RESET_LO);
  localparam logic [TW-1:0] RST_HI_TW = TW'(RST_HI_INT);
  localparam logic [TW-1:0] RST_CNT   = (RESET_LO < RST_HI_INT) ? TW'(RST_HI_INT - RESET_LO) : '0;
  localparam logic [TW-1:0] ONE_TW    = {{(TW-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] mask_f(input int l, input int h);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i >= l) && (i < h) && (i < LIMIT);
    end
    return m;
  endfunction

  localparam logic [WIDTH-1:0] RST_MASK = mask_f(RESET_LO, RST_HI_INT);

  state_t           state_r, state_nx_s;
  logic [TW-1:0]    cur_lo_r, cur_hi_r, lo_nx_s, hi_nx_s, cnt_s;
  logic             upd_s, done_nx_s;
  logic [WIDTH-1:0] mask_s;

  // Per-bit window decode of the next bounds; bits at or above LIMIT never set.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < LIMIT) begin : g_live
      assign mask_s[i] = (lo_nx_s <= TW'(i)) && (TW'(i) < hi_nx_s);
    end else begin : g_dead
      assign mask_s[i] = 1'b0;
    end
  end

  assign cnt_s      = (lo_nx_s < hi_nx_s) ? (hi_nx_s - lo_nx_s) : '0;
  assign load_ready = (state_r == IDLE);

  // Next-state, next-bounds and update-enable decode.
  always_comb begin
    state_nx_s = state_r;
    lo_nx_s    = cur_lo_r;
    hi_nx_s    = cur_hi_r;
    upd_s      = 1'b0;
    done_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_valid) begin
          lo_nx_s = load_lo;
          hi_nx_s = (load_hi > LIMIT_TW) ? LIMIT_TW : load_hi;
          upd_s   = 1'b1;
          if (load_sweep && (load_lo < hi_nx_s)) begin
            state_nx_s = SWEEP;
          end else begin
            done_nx_s = 1'b1;
          end
        end else begin
          upd_s = 1'b0;
        end
      end
      SWEEP: begin
        lo_nx_s = cur_lo_r + ONE_TW;
        upd_s   = 1'b1;
        if (lo_nx_s == cur_hi_r) begin
          state_nx_s = IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = SWEEP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, bounds and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cur_lo_r <= RST_LO_TW;
      cur_hi_r <= RST_HI_TW;
      out      <= RST_MASK;
      ones     <= RST_CNT;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      cur_lo_r <= lo_nx_s;
      cur_hi_r <= hi_nx_s;
      done     <= done_nx_s;
      busy     <= (state_nx_s == SWEEP);
      if (upd_s) begin
        out  <= mask_s;
        ones <= cnt_s;
      end
    end
  end

endmodule

// File: tb/tb_gen_mask_sweep.sv
// Directed bench for gen_mask_sweep (WIDTH=32, LIMIT=31, RESET_LO=8).
module tb_gen_mask_sweep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [5:0]  load_lo = 6'd0;
  logic [5:0]  load_hi = 6'd0;
  logic        load_sweep = 1'b0;
  logic [31:0] out;
  logic [5:0]  ones;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  gen_mask_sweep #(.WIDTH(32), .LIMIT(31), .RESET_LO(8)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_lo(load_lo), .load_hi(load_hi), .load_sweep(load_sweep),
    .out(out), .ones(ones), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] lo, input logic [5:0] hi, input logic sw);
    load_lo = lo; load_hi = hi; load_sweep = sw; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] o, input logic [5:0] c,
                           input logic b, input logic d);
    check({tag, ".out"}, out, o);
    check({tag, ".ones"}, {26'd0, ones}, {26'd0, c});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".done"}, {31'd0, done}, {31'd0, d});
    check({tag, ".rdy"}, {31'd0, load_ready}, {31'd0, ~b});
    check({tag, ".bit31"}, {31'd0, out[31]}, 32'd0);
  endtask

  initial begin
    #22 rst = 1'b0;
    chk_state("reset", 32'h7FFFFF00, 6'd23, 1'b0, 1'b0);
    repeat (10) tick();
    chk_state("hold", 32'h7FFFFF00, 6'd23, 1'b0, 1'b0);

    load(6'd0, 6'd8, 1'b0);
    chk_state("static", 32'h000000FF, 6'd8, 1'b0, 1'b1);
    tick();
    chk_state("static_hold", 32'h000000FF, 6'd8, 1'b0, 1'b0);

    load(6'd0, 6'd32, 1'b0);
    chk_state("clamp", 32'h7FFFFFFF, 6'd31, 1'b0, 1'b1);
    tick();

    load(6'd4, 6'd8, 1'b1);
    chk_state("sw0", 32'h000000F0, 6'd4, 1'b1, 1'b0);
    load_lo = 6'd0; load_hi = 6'd2; load_sweep = 1'b0; load_valid = 1'b1;
    tick();
    chk_state("sw1", 32'h000000E0, 6'd3, 1'b1, 1'b0);
    tick();
    chk_state("sw2", 32'h000000C0, 6'd2, 1'b1, 1'b0);
    load_valid = 1'b0;
    tick();
    chk_state("sw3", 32'h00000080, 6'd1, 1'b1, 1'b0);
    tick();
    chk_state("sw4", 32'h00000000, 6'd0, 1'b0, 1'b1);
    tick();
    chk_state("sw_after", 32'h00000000, 6'd0, 1'b0, 1'b0);

    load(6'd5, 6'd5, 1'b0);
    load_lo = 6'd0; load_hi = 6'd8; load_sweep = 1'b0;
    chk_state("empty_static", 32'h00000000, 6'd0, 1'b0, 1'b1);
    tick();
    chk_state("empty_static_hold", 32'h00000000, 6'd0, 1'b0, 1'b0);
    load(6'd20, 6'd3, 1'b1);
    chk_state("empty_sweep", 32'h00000000, 6'd0, 1'b0, 1'b1);
    tick();
    load(6'd40, 6'd31, 1'b0);
    chk_state("lo_over", 32'h00000000, 6'd0, 1'b0, 1'b1);
    tick();

    load(6'd0, 6'd31, 1'b1);
    chk_state("rs0", 32'h7FFFFFFF, 6'd31, 1'b1, 1'b0);
    tick();
    chk_state("rs1", 32'h7FFFFFFE, 6'd30, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_state("async_rst", 32'h7FFFFF00, 6'd23, 1'b0, 1'b0);
    rst = 1'b0;
    load(6'd2, 6'd5, 1'b0);
    chk_state("post_rst", 32'h0000001C, 6'd3, 1'b0, 1'b1);

    load(6'd1, 6'd2, 1'b0);
    chk_state("b2b", 32'h00000002, 6'd1, 1'b0, 1'b1);
    load(6'd6, 6'd7, 1'b1);
    chk_state("sw1bit0", 32'h00000040, 6'd1, 1'b1, 1'b0);
    tick();
    chk_state("sw1bit1", 32'h00000000, 6'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
